// File: rtl/axis_window_rx.sv
`default_nettype none
// ============================================================================
// Module      : axis_window_rx
// Description : AXI-Stream pixel receiver that rebuilds 3x3 sliding windows
//               (valid convolution) from a row-major single-channel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_window_rx #(
    parameter int PIXEL_WIDTH = 16,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic signed [PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    input  logic                          win_ready,
    output logic signed [PIXEL_WIDTH-1:0] x00,
    output logic signed [PIXEL_WIDTH-1:0] x01,
    output logic signed [PIXEL_WIDTH-1:0] x02,
    output logic signed [PIXEL_WIDTH-1:0] x10,
    output logic signed [PIXEL_WIDTH-1:0] x11,
    output logic signed [PIXEL_WIDTH-1:0] x12,
    output logic signed [PIXEL_WIDTH-1:0] x20,
    output logic signed [PIXEL_WIDTH-1:0] x21,
    output logic signed [PIXEL_WIDTH-1:0] x22,
    output logic                          win_valid,
    output logic                          Done_1row,
    output logic                          frame_done,
    output logic                          tlast_err,
    output logic                          busy
);

    localparam int                   c_AW       = $clog2(IMG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_LAST_COL = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_LAST_ROW = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] c_TWO      = CNT_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_WIDTH-1:0]          r_row;
    logic [CNT_WIDTH-1:0]          r_col;
    logic [c_AW-1:0]               w_idx;
    logic signed [PIXEL_WIDTH-1:0] r_lbuf0 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] r_lbuf1 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] r_win   [3][3];

    logic r_win_valid;
    logic r_done_1row;
    logic r_frame_done;
    logic r_tlast_err;

    logic w_out_free;
    logic w_tready;
    logic w_busy;
    logic w_accept;
    logic w_last_col;
    logic w_last_row;
    logic w_last_beat;
    logic w_emit;
    logic w_frame_end;

    // The single output stage may be refilled in the same cycle it is consumed.
    assign w_out_free  = !r_win_valid || win_ready;
    assign w_accept    = w_tready && s_axis_tvalid;
    assign w_last_col  = (r_col == c_LAST_COL);
    assign w_last_row  = (r_row == c_LAST_ROW);
    assign w_last_beat = w_last_col && w_last_row;
    assign w_emit      = w_accept && (r_row >= c_TWO) && (r_col >= c_TWO);
    assign w_idx       = r_col[c_AW-1:0];

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tready    = 1'b0;
        w_busy      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                w_busy   = 1'b1;
                w_tready = w_out_free;
                if (w_out_free && s_axis_tvalid && w_last_beat) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_out_free) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame geometry comes only from the parameters; tlast is merely audited.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers hold no reset: stale rows are never emitted because rows 0..1
    // of every frame only refill them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbuf1[w_idx] <= r_lbuf0[w_idx];
            r_lbuf0[w_idx] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_lbuf1[w_idx];
            r_win[1][2] <= r_lbuf0[w_idx];
            r_win[2][2] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_win_valid  <= 1'b0;
            r_done_1row  <= 1'b0;
            r_frame_done <= 1'b0;
            r_tlast_err  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_done_1row <= w_last_col;
            end else if (r_win_valid && win_ready) begin
                r_win_valid <= 1'b0;
                r_done_1row <= 1'b0;
            end
            if (w_accept && (s_axis_tlast != w_last_beat)) begin
                r_tlast_err <= 1'b1;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign busy          = w_busy;
    assign win_valid     = r_win_valid;
    assign Done_1row     = r_done_1row;
    assign frame_done    = r_frame_done;
    assign tlast_err     = r_tlast_err;

    assign x00 = r_win[0][0];
    assign x01 = r_win[0][1];
    assign x02 = r_win[0][2];
    assign x10 = r_win[1][0];
    assign x11 = r_win[1][1];
    assign x12 = r_win[1][2];
    assign x20 = r_win[2][0];
    assign x21 = r_win[2][1];
    assign x22 = r_win[2][2];

endmodule
`default_nettype wire

// File: tb/tb_axis_window_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_window_rx
// Description : Scoreboard bench for axis_window_rx (4x4 and 5x3 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_window_rx;
    localparam int PW = 16;

    typedef struct packed {
        logic [8:0][PW-1:0] p;
        logic               done;
        logic               last;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    win_t q_a[$];
    win_t q_b[$];

    // DUT A: 4x4
    logic a_rst, a_start, a_tvalid, a_tlast, a_tready, a_wrdy;
    logic signed [PW-1:0] a_tdata;
    logic signed [PW-1:0] a_x00, a_x01, a_x02, a_x10, a_x11, a_x12, a_x20, a_x21, a_x22;
    logic a_valid, a_done, a_fdone, a_terr, a_busy;
    logic [8:0][PW-1:0] a_win;
    assign a_win = {a_x22, a_x21, a_x20, a_x12, a_x11, a_x10, a_x02, a_x01, a_x00};

    // DUT B: 5x3
    logic b_rst, b_start, b_tvalid, b_tlast, b_tready, b_wrdy;
    logic signed [PW-1:0] b_tdata;
    logic signed [PW-1:0] b_x00, b_x01, b_x02, b_x10, b_x11, b_x12, b_x20, b_x21, b_x22;
    logic b_valid, b_done, b_fdone, b_terr, b_busy;
    logic [8:0][PW-1:0] b_win;
    assign b_win = {b_x22, b_x21, b_x20, b_x12, b_x11, b_x10, b_x02, b_x01, b_x00};

    axis_window_rx #(.PIXEL_WIDTH(PW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .Reset(a_rst), .start(a_start),
        .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast),
        .s_axis_tready(a_tready), .win_ready(a_wrdy),
        .x00(a_x00), .x01(a_x01), .x02(a_x02), .x10(a_x10), .x11(a_x11), .x12(a_x12),
        .x20(a_x20), .x21(a_x21), .x22(a_x22),
        .win_valid(a_valid), .Done_1row(a_done), .frame_done(a_fdone),
        .tlast_err(a_terr), .busy(a_busy)
    );

    axis_window_rx #(.PIXEL_WIDTH(PW), .IMG_WIDTH(5), .IMG_HEIGHT(3), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .Reset(b_rst), .start(b_start),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
        .s_axis_tready(b_tready), .win_ready(b_wrdy),
        .x00(b_x00), .x01(b_x01), .x02(b_x02), .x10(b_x10), .x11(b_x11), .x12(b_x12),
        .x20(b_x20), .x21(b_x21), .x22(b_x22),
        .win_valid(b_valid), .Done_1row(b_done), .frame_done(b_fdone),
        .tlast_err(b_terr), .busy(b_busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected windows: pixel(r,c) = w*r + c, optionally negated.
    task automatic push_exp(input bit to_b, input int w, input int h, input bit neg);
        win_t e;
        for (int k = 0; k < h - 2; k++) begin
            for (int j = 0; j < w - 2; j++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        int v;
                        v = w * (k + r) + j + c;
                        e.p[3*r+c] = PW'(neg ? -v : v);
                    end
                end
                e.done = (j == w - 3);
                e.last = (k == h - 3) && (j == w - 3);
                if (to_b) q_b.push_back(e);
                else      q_a.push_back(e);
            end
        end
    endtask

    // Monitor A
    logic fd_exp_a = 1'b0;
    int   a_widx = 0;
    logic [8:0][PW-1:0] a_first, a_last;
    always @(negedge clk) begin
        win_t e;
        if (fd_exp_a || a_fdone) chk("a_frame_done_timing", a_fdone, fd_exp_a);
        fd_exp_a = 1'b0;
        if (a_valid && !a_rst) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_window: got x00=%0d x22=%0d, required none", a_x00, a_x22);
            end else begin
                if ({a_win, a_done} !== {q_a[0].p, q_a[0].done}) begin
                    bad++;
                    $display("FAIL a_window: got %h done=%b required %h done=%b",
                             a_win, a_done, q_a[0].p, q_a[0].done);
                end
                if (!a_wrdy) chk("a_tready_while_stalled", a_tready, 0);
                else begin
                    e = q_a.pop_front();
                    if (a_widx == 0) a_first = a_win;
                    if (e.last) a_last = a_win;
                    a_widx++;
                    fd_exp_a = e.last;
                end
            end
        end
    end

    // Monitor B
    logic fd_exp_b = 1'b0;
    int   b_widx = 0;
    always @(negedge clk) begin
        win_t e;
        if (fd_exp_b || b_fdone) chk("b_frame_done_timing", b_fdone, fd_exp_b);
        fd_exp_b = 1'b0;
        if (b_valid && !b_rst) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_window: got x00=%0d, required none", b_x00);
            end else begin
                if ({b_win, b_done} !== {q_b[0].p, q_b[0].done}) begin
                    bad++;
                    $display("FAIL b_window: got %h done=%b required %h done=%b",
                             b_win, b_done, q_b[0].p, q_b[0].done);
                end
                if (b_wrdy) begin
                    e = q_b.pop_front();
                    b_widx++;
                    fd_exp_b = e.last;
                end
            end
        end
    end

    task automatic send_a(input int gap_pct, input int tlast_idx, input int nbeats);
        bit ok;
        int n;
        for (int i = 0; i < nbeats; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                a_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            a_tvalid = 1'b1;
            a_tdata  = PW'(i);  // 4x4: 4*r + c == beat index
            a_tlast  = (i == tlast_idx);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 50) begin
                @(negedge clk); ok = a_tready;
                @(posedge clk); #1;
                n++;
            end
            if (!ok) chk("a_tready_timeout", 0, 1);
        end
        a_tvalid = 1'b0;
        a_tlast  = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!a_fdone && n < 100);
        chk("a_frame_done_seen", a_fdone, 1);
        @(posedge clk); #1;
        chk("a_queue_empty", q_a.size(), 0);
    endtask

    task automatic start_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic run_full_a(input int gap_pct, input int tlast_idx);
        a_widx = 0;
        push_exp(1'b0, 4, 4, 1'b0);
        start_a();
        send_a(gap_pct, tlast_idx, 16);
        wait_done_a();
        chk("a_window_count", a_widx, 4);
    endtask

    initial begin
        int n;
        bit ok;
        a_rst = 1; a_start = 0; a_tvalid = 0; a_tlast = 0; a_tdata = '0; a_wrdy = 1;
        b_rst = 1; b_start = 0; b_tvalid = 0; b_tlast = 0; b_tdata = '0; b_wrdy = 1;
        repeat (3) @(posedge clk);
        #1;
        a_rst = 0; b_rst = 0;
        @(negedge clk);
        chk("rst_tready", a_tready, 0);
        chk("rst_win_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_frame_done", a_fdone, 0);
        chk("rst_tlast_err", a_terr, 0);
        chk("rst_done_1row", a_done, 0);
        chk("rst_x00", a_x00, 0);
        chk("rst_x22", a_x22, 0);
        @(posedge clk); #1;

        // Gapless 4x4 frame with hand-derived corner pixels
        run_full_a(0, 15);
        chk("first_x00", a_first[0], 0);
        chk("first_x02", a_first[2], 2);
        chk("first_x20", a_first[6], 8);
        chk("first_x22", a_first[8], 10);
        chk("last_x00", a_last[0], 5);
        chk("last_x22", a_last[8], 15);
        chk("tlast_err_clean", a_terr, 0);

        // Consumer stalls for 3 cycles on the first window
        a_wrdy = 1'b0;
        a_widx = 0;
        push_exp(1'b0, 4, 4, 1'b0);
        start_a();
        fork
            send_a(0, 15, 16);
            begin
                n = 0;
                do begin
                    @(negedge clk); n++;
                end while (!a_valid && n < 100);
                chk("stall_window_appeared", a_valid, 1);
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                a_wrdy = 1'b1;
            end
        join
        wait_done_a();
        chk("stall_window_count", a_widx, 4);

        // Random 50% tvalid gaps
        run_full_a(50, 15);

        // Early tlast on beat 10 of 16
        run_full_a(0, 9);
        chk("tlast_err_set", a_terr, 1);

        // Reset after 9 beats
        start_a();
        send_a(0, -1, 9);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", a_busy, 0);
        chk("abort_win_valid", a_valid, 0);
        chk("abort_tready", a_tready, 0);
        chk("abort_tlast_err_cleared", a_terr, 0);
        chk("abort_no_windows_pending", q_a.size(), 0);
        @(posedge clk); #1;
        run_full_a(0, 15);

        // 5x3 frame with negative pixels
        b_widx = 0;
        push_exp(1'b1, 5, 3, 1'b1);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            b_tvalid = 1'b1;
            b_tdata  = PW'(-i);  // 5x3: -(5r + c) == -beat index
            b_tlast  = (i == 14);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 50) begin
                @(negedge clk); ok = b_tready;
                @(posedge clk); #1;
                n++;
            end
            if (!ok) chk("b_tready_timeout", 0, 1);
        end
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!b_fdone && n < 100);
        chk("b_frame_done_seen", b_fdone, 1);
        @(posedge clk); #1;
        chk("b_window_count", b_widx, 3);
        chk("b_queue_empty", q_b.size(), 0);
        chk("b_tlast_err", b_terr, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
